// File: rtl/reg_share_arb_pkg.sv
// Shared types and defaults for the two-requester shared-register arbiter.
package reg_share_arb_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/reg8.sv
// Shared data register: synchronous reset wins over the write enable.
module reg8 #(
  parameter int unsigned WIDTH = reg_share_arb_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic [WIDTH-1:0] Reg_In,
  output logic [WIDTH-1:0] Reg_Out
);

  logic [WIDTH-1:0] reg_q;

  always_ff @(posedge clk) begin
    if (res) begin
      reg_q <= '0;
    end else if (EN) begin
      reg_q <= Reg_In;
    end
  end

  assign Reg_Out = reg_q;

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter granting two requesters one write each into a shared
// register, with owner tracking and a completed-write counter.
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] Reg_Out,
  output logic             last_owner,
  output logic [CNT_W-1:0] wr_cnt
);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             en_c;
  logic [WIDTH-1:0] reg_in_c;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      prio_q       <= 1'b0;
      last_owner_q <= 1'b0;
      wr_cnt_q     <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      prio_q       <= prio_d;
      last_owner_q <= last_owner_d;
      wr_cnt_q     <= wr_cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    prio_d       = prio_q;
    last_owner_d = last_owner_q;
    wr_cnt_d     = wr_cnt_q;
    en_c         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d   = (req0 && req1) ? prio_q : req1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        en_c    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        prio_d       = ~sel_q;
        last_owner_d = sel_q;
        wr_cnt_d     = wr_cnt_q + CNT_W'(1);
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Grant/busy are registered from the next state so they line up with it.
    gnt0_d = (state_d == WRITE) && !sel_d;
    gnt1_d = (state_d == WRITE) && sel_d;
    busy_d = (state_d != IDLE);
  end

  assign reg_in_c = sel_q ? data1 : data0;

  reg8 #(
    .WIDTH(WIDTH)
  ) u_reg8 (
    .clk    (clk),
    .res    (res),
    .EN     (en_c),
    .Reg_In (reg_in_c),
    .Reg_Out(Reg_Out)
  );

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign busy       = busy_q;
  assign last_owner = last_owner_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a cycle-stamp model.
module tb_reg_share_arb;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             res;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, busy, last_owner;
  logic [WIDTH-1:0] Reg_Out;
  logic [CNT_W-1:0] wr_cnt;

  int total = 0;
  int bad   = 0;

  reg_share_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .res       (res),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .Reg_Out   (Reg_Out),
    .last_owner(last_owner),
    .wr_cnt    (wr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a write accepted at edge n grants during the following cycle,
  // lands in the register at edge n+1 and retires (counter/owner/prio) at n+2.
  int cyc = 0;
  int m_acc = -1;
  int m_win = 0;
  int m_prio = 0;
  int m_owner = 0;
  int m_cnt = 0;
  int m_reg = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    bit r0, r1, rs;
    int d0, d1;
    r0 = req0; r1 = req1; rs = res;
    d0 = int'(data0); d1 = int'(data1);
    cyc++;
    if (rs) begin
      m_reg = 0; m_cnt = 0; m_owner = 0; m_prio = 0; m_acc = -1; m_win = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_acc >= 0 && cyc == m_acc + 1) m_reg = (m_win != 0) ? d1 : d0;
      if (m_acc >= 0 && cyc == m_acc + 2) begin
        m_prio  = 1 - m_win;
        m_owner = m_win;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        m_acc   = -1;
      end else if (m_acc < 0 && (r0 || r1)) begin
        m_win = (r0 && r1) ? m_prio : (r1 ? 1 : 0);
        m_acc = cyc;
      end
    end
    #1;
    if (m_valid) begin
      check("gnt0",       int'(gnt0),    (m_acc == cyc && m_win == 0) ? 1 : 0);
      check("gnt1",       int'(gnt1),    (m_acc == cyc && m_win == 1) ? 1 : 0);
      check("busy",       int'(busy),    (m_acc >= 0) ? 1 : 0);
      check("Reg_Out",    int'(Reg_Out), m_reg);
      check("last_owner", int'(last_owner), m_owner);
      check("wr_cnt",     int'(wr_cnt),  m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'h12; data1 = 8'h34;

    // Reset held two cycles with both requests high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_reg",  int'(Reg_Out), 8'h00);
      check("rst_gnt",  int'({gnt1, gnt0}), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cnt",  int'(wr_cnt), 0);
    end
    res = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();

    // Single request from requester 0.
    req0 = 1'b1; data0 = 8'h77;
    tick();
    check("single_gnt0", int'(gnt0), 1);
    req0 = 1'b0;
    tick();
    check("single_gnt0_off", int'(gnt0), 0);
    check("single_reg", int'(Reg_Out), 8'h77);
    tick();
    check("single_owner", int'(last_owner), 0);
    check("single_cnt", int'(wr_cnt), 1);

    // Contention from a fresh reset: grants alternate starting with 0.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hAA; data1 = 8'h55;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("cont_gnt", int'({gnt1, gnt0}), (k % 2 == 0) ? 1 : 2);
      tick();
      check("cont_reg", int'(Reg_Out), (k % 2 == 0) ? 8'hAA : 8'h55);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset landing on the WRITE cycle aborts the write.
    do_reset();
    req1 = 1'b1; data1 = 8'h3C;
    tick();
    check("abort_gnt1", int'(gnt1), 1);
    res = 1'b1;
    tick();
    check("abort_reg", int'(Reg_Out), 0);
    check("abort_cnt", int'(wr_cnt), 0);
    check("abort_busy", int'(busy), 0);
    res = 1'b0; req1 = 1'b0;
    tick();
    check("abort_idle", int'(busy), 0);

    // Sixteen back-to-back writes wrap the counter.
    do_reset();
    req0 = 1'b1; data0 = 8'h11;
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      tick();
      if (i == 14) check("wrap_15", int'(wr_cnt), 15);
      if (i == 15) check("wrap_0", int'(wr_cnt), 0);
    end
    req0 = 1'b0;
    tick();

    // Late request raised during DONE of a requester-0 write.
    do_reset();
    req0 = 1'b1; data0 = 8'h5A;
    tick();
    check("late_gnt0", int'(gnt0), 1);
    req0 = 1'b0;
    tick();
    req1 = 1'b1; data1 = 8'hC3;
    tick();
    check("late_gnt1_early", int'(gnt1), 0);
    tick();
    check("late_gnt1", int'(gnt1), 1);
    req1 = 1'b0;
    tick();
    check("late_reg", int'(Reg_Out), 8'hC3);
    tick();
    check("late_owner", int'(last_owner), 1);

    // Randomized traffic: hold requests until granted, occasional early drops and resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (req0 && gnt0 && ($urandom_range(1) == 1)) req0 = 1'b0;
      else if (req0 && ($urandom_range(40) == 0)) req0 = 1'b0;
      else if (!req0 && ($urandom_range(2) == 0)) begin
        req0 = 1'b1; data0 = WIDTH'($urandom);
      end
      if (req1 && gnt1 && ($urandom_range(1) == 1)) req1 = 1'b0;
      else if (req1 && ($urandom_range(40) == 0)) req1 = 1'b0;
      else if (!req1 && ($urandom_range(2) == 0)) begin
        req1 = 1'b1; data1 = WIDTH'($urandom);
      end
      res = ($urandom_range(99) == 0);
      tick();
    end
    res = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter WIDTH, default 8: data width of the shared register.
REQ-002 Parameter CNT_W, default 4: width of the completed-write counter.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 res  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req0  input  1  requester 0 write request, level; held until its grant.
REQ-006 req1  input  1  requester 1 write request, level; held until its grant.
REQ-007 data0  input  WIDTH  requester 0 write data; stable while req0 is high.
REQ-008 data1  input  WIDTH  requester 1 write data; stable while req1 is high.
REQ-009 gnt0  output  1  one-cycle grant to requester 0; write occurs at the end of this cycle.
REQ-010 gnt1  output  1  one-cycle grant to requester 1; write occurs at the end of this cycle.
REQ-011 busy  output  1  high in WRITE and DONE states.
REQ-012 Reg_Out  output  WIDTH  current contents of the shared register.
REQ-013 last_owner  output  1  id of the requester that performed the most recent completed write.
REQ-014 wr_cnt  output  CNT_W  count of completed writes, modulo 2^CNT_W.

Function
REQ-015 FSM states: IDLE, WRITE, DONE. All outputs except Reg_Out are registered or decoded from the state (Moore).
REQ-016 IDLE: if req0 or req1 is high, latch the winner id into sel and go to WRITE; otherwise stay in IDLE.
REQ-017 Arbitration is round-robin: priority pointer prio (0 or 1); if both requests are high, the winner is prio; if only one is high, that one wins.
REQ-018 WRITE: gnt[sel] = 1 for exactly one cycle, other grant 0; shared register EN = 1 and Reg_In = data[sel]; next state DONE.
REQ-019 Reg_Out shows the new value from the first cycle of DONE, so latency is 2 clocks from a request sampled in IDLE to updated Reg_Out.
REQ-020 DONE: prio <= ~sel, last_owner <= sel, wr_cnt <= wr_cnt + 1 (wraps 2^CNT_W-1 -> 0); next state IDLE.
REQ-021 Requests are ignored in WRITE and DONE, not queued. Peak throughput is one write per 3 cycles.
REQ-022 A requester whose request drops before grant is simply not served. A drop during WRITE does not abort the write.
REQ-023 Shared register EN = 0 in every state except WRITE; Reg_Out holds its value otherwise.

Reset
REQ-024 When res = 1 at a rising edge, the block SHALL enter IDLE with prio = 0, sel = 0, last_owner = 0, wr_cnt = 0, Reg_Out = 0, gnt0 = gnt1 = 0 and busy = 0.
REQ-025 Reset in WRITE SHALL abort the write: Reg_Out = 0 and wr_cnt is not incremented. Reset has priority over EN.
REQ-026 Reset in DONE SHALL discard the pending prio, last_owner and wr_cnt updates.
REQ-027 While res stays high, all outputs SHALL hold their reset values and requests SHALL be ignored.

Structure
REQ-028 Shared package SHALL hold the state typedef/encoding (IDLE = 2'b00, WRITE = 2'b01, DONE = 2'b10), the WIDTH default and the CNT_W default.
REQ-029 The shared register SHALL be one instantiated sub-module reg8, with ports clk, res, EN, Reg_In, Reg_Out and synchronous reset.
REQ-030 Arbitration, FSM and counter SHALL be in reg_share_arb.

Verification
REQ-031 Reset: res = 1 for 2 cycles with req0 = req1 = 1 -> Reg_Out = 8'h00, gnt0 = gnt1 = 0, busy = 0, wr_cnt = 0.
REQ-032 Single request: req0 = 1, data0 = 8'h77 -> gnt0 high for 1 cycle 1 clock later; Reg_Out = 8'h77 2 clocks after request; last_owner = 0; wr_cnt = 1.
REQ-033 Contention: req0 = req1 = 1 continuously, data0 = 8'hAA, data1 = 8'h55 -> grants alternate gnt0, gnt1, gnt0, ... every 3 cycles; Reg_Out alternates AA/55.
REQ-034 Reset mid-operation: res = 1 during the WRITE cycle of a data1 = 8'h3C grant -> Reg_Out = 8'h00, wr_cnt unchanged at 0, state IDLE.
REQ-035 Counter wrap: 16 back-to-back single-requester writes -> wr_cnt reads 15 then 0; no grant is issued while busy = 1.
REQ-036 Late request: req1 raised in DONE of a req0 write -> req1 is served starting at the next IDLE; gnt1 appears 2 cycles after it rose.
